// File: rtl/fifo_reader_pkg.sv
// fifo_stream_reader shared types.
// State encoding, latency constant, word type.
package fifo_reader_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int READ_LATENCY = 1;
  localparam int DEF_FIFO_WIDTH = 16;

  typedef logic [DEF_FIFO_WIDTH-1:0] word_t;

  // 1-bit circular pointer step.
  function automatic logic ptr_inc(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// prefetch_buf: 2-entry circular buffer.
// Absorbs the FIFO read latency.
module prefetch_buf
  import fifo_reader_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [1:0]   occ,
  output logic [W-1:0] dout
);

  logic         head_q, head_d;
  logic         tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         do_pop;
  logic         do_push;

  assign empty   = (occ_q == 2'd0);
  assign full    = (occ_q == 2'(DEPTH));
  assign occ     = occ_q;
  assign dout    = mem_q[head_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer, occupancy and storage update.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    mem_d  = mem_q;
    if (clr) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = din;
        tail_d        = ptr_inc(tail_q);
      end
      if (do_pop) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage needs no reset; occ gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: FIFO read side to
// valid/ready stream with flush and counters.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  underflow_err
);

  state_e               state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 uerr_q, uerr_d;
  logic                 run;
  logic [1:0]           occ;
  logic [1:0]           pending;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 buf_push;
  logic                 buf_pop;
  logic                 buf_clr;

  assign run     = !rst && (state_q == RUN);
  assign pending = occ + {1'b0, inflight_q};

  // A same-cycle pop does not free a slot.
  assign fifo_rd_en = run && !fifo_empty &&
                      (pending < 2'(BUF_DEPTH));

  assign m_valid  = run && !buf_empty;
  assign buf_clr  = run && flush;
  assign buf_push = run && inflight_q && !flush;
  assign buf_pop  = m_valid && m_ready && !flush;

  prefetch_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (buf_clr),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (fifo_data_out),
    .full  (buf_full),
    .empty (buf_empty),
    .occ   (occ),
    .dout  (m_data)
  );

  // Flush holds until the last in-flight read lands.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   if (!inflight_q) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Read tracking, delivery count, sticky error.
  always_comb begin
    inflight_d = fifo_rd_en;
    cnt_d      = cnt_q;
    if (buf_pop) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    uerr_d = uerr_q | fifo_underflow;
  end

  // Registered control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      uerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      uerr_q     <= uerr_d;
    end
  end

  assign word_count    = cnt_q;
  assign underflow_err = uerr_q;

  // Capture must never overflow the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(buf_push && buf_full && !buf_pop))
        else $error("prefetch buffer overflow");
      assert (pending <= 2'(BUF_DEPTH))
        else $error("occ + inflight exceeds depth");
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model,
// directed tests, scoreboard monitor.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_underflow = 1'b0;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_count;
  logic        underflow_err;

  int checks = 0;
  int errors = 0;
  int nreads = 0;

  logic [15:0] fq[$];
  logic [15:0] expq[$];

  logic        s_rd, s_valid, s_uerr;
  logic [15:0] s_data, s_cnt;

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .flush          (flush),
    .word_count     (word_count),
    .underflow_err  (underflow_err)
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               name, got, want);
    end
  endtask

  // One clock: sample at negedge, then model FIFO read.
  task automatic step();
    logic rd;
    @(negedge clk);
    rd      = fifo_rd_en;
    s_rd    = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_cnt   = word_count;
    s_uerr  = underflow_err;
    @(posedge clk);
    #1;
    if (rd) nreads++;
    if (rd && fq.size() != 0) fifo_data_out = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic load(input logic [15:0] w, input bit expect_out);
    fq.push_back(w);
    if (expect_out) expq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, expq.size(), 0);
    step();
  endtask

  // Scoreboard monitor: compares every accepted word.
  initial begin
    logic        hold;
    logic [15:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (hold && m_valid && !rst)
        chk("stall_stable", m_data, held);
      if (!rst && m_valid && m_ready && !flush) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", m_data, 32'hffff_ffff);
        end else begin
          chk("data", m_data, expq.pop_front());
        end
      end
      hold = !rst && m_valid && !m_ready && !flush;
      held = m_data;
    end
  end

  initial begin
    // Test 1: preload 8 words, streaming
    for (int i = 1; i <= 8; i++) load(16'(i), 1'b1);
    m_ready = 1'b1;
    step();
    chk("reset_rd_en", s_rd, 0);
    chk("reset_valid", s_valid, 0);
    rst = 1'b0;
    step();
    chk("t1_rd_first", s_rd, 1);
    chk("t1_valid_c0", s_valid, 0);
    chk("reset_cnt", s_cnt, 0);
    chk("reset_uerr", s_uerr, 0);
    step();
    chk("t1_valid_c1", s_valid, 0);
    step();
    chk("t1_valid_c2", s_valid, 1);
    chk("t1_first_data", s_data, 16'h0001);
    drain("t1_drain", 40);
    chk("t1_count", s_cnt, 8);

    // Test 2: back-pressure, only 2 reads issued
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) load(16'(i), 1'b1);
    do_reset();
    nreads = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t2_reads", nreads, 2);
    chk("t2_rd_idle", s_rd, 0);
    chk("t2_hold_valid", s_valid, 1);
    chk("t2_hold_data", s_data, 16'h0001);
    m_ready = 1'b1;
    drain("t2_drain", 40);
    chk("t2_count", s_cnt, 4);

    // Test 3: toggling ready
    do_reset();
    for (int i = 1; i <= 6; i++) load(16'h0100 + 16'(i), 1'b1);
    for (int i = 0; i < 60 && expq.size() != 0; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    chk("t3_drain", expq.size(), 0);
    m_ready = 1'b0;
    step();
    chk("t3_count", s_cnt, 6);

    // Test 4a: flush with a read in flight
    do_reset();
    load(16'h0201, 1'b0);
    load(16'h0202, 1'b0);
    for (int i = 3; i <= 6; i++) load(16'h0200 + 16'(i), 1'b1);
    step();
    flush = 1'b1;
    step();
    chk("t4_rd_in_flush_cycle", s_rd, 1);
    flush = 1'b0;
    step();
    chk("t4_valid_f0", s_valid, 0);
    chk("t4_rd_f0", s_rd, 0);
    step();
    chk("t4_valid_f1", s_valid, 0);
    chk("t4_rd_f1", s_rd, 0);
    step();
    chk("t4_rd_resume", s_rd, 1);
    m_ready = 1'b1;
    drain("t4_drain", 40);
    chk("t4_count", s_cnt, 4);

    // Test 4b: flush beats m_ready, buffer full
    m_ready = 1'b0;
    load(16'h0310, 1'b0);
    load(16'h0311, 1'b0);
    load(16'h0312, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("t4b_full_valid", s_valid, 1);
    m_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t4b_valid_flush", s_valid, 0);
    drain("t4b_drain", 40);
    chk("t4b_count", s_cnt, 5);

    // Test 5: sticky underflow, streaming unaffected
    for (int i = 0; i < 3; i++) load(16'h0400 + 16'(i), 1'b1);
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    step();
    chk("t5_uerr_set", s_uerr, 1);
    drain("t5_drain", 40);
    chk("t5_uerr_sticky", s_uerr, 1);
    chk("t5_count", s_cnt, 8);

    // Test 6: reset mid-stream with occ=2
    m_ready = 1'b0;
    load(16'h0500, 1'b0);
    load(16'h0501, 1'b0);
    for (int i = 2; i < 8; i++) load(16'h0500 + 16'(i), 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_pre_valid", s_valid, 1);
    rst = 1'b1;
    step();
    step();
    chk("t6_rst_valid", s_valid, 0);
    chk("t6_rst_rd", s_rd, 0);
    chk("t6_rst_cnt", s_cnt, 0);
    chk("t6_rst_uerr", s_uerr, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    drain("t6_drain", 60);
    chk("t6_count", s_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
